// File: rtl/burst_if_pkg.sv
// Shared definitions for the single-wire burst handshake (initiator and responder).
package burst_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } burst_state_e;

  localparam int LEN_W_DEF = 8;

  // Width needed to hold a timeout count of 0..tmo inclusive
  function automatic int tmo_w(input int tmo);
    return $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/burst_initiator_if.sv
// Command-side and responder-side signals of one burst initiator.
interface burst_initiator_if import burst_if_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF
);
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             do_req;
  logic             s;
  logic             g;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] rx_cnt;

  modport master (
    input  cmd_valid, cmd_len, s, g,
    output cmd_ready, do_req, done, err, rx_cnt
  );

  modport slave (
    output cmd_valid, cmd_len, s, g,
    input  cmd_ready, do_req, done, err, rx_cnt
  );
endinterface

// File: rtl/burst_tmo_cnt.sv
// Loadable up-counter with synchronous clear and a terminal-count flag; holds at TC.
module burst_tmo_cnt #(
  parameter int W  = 5,
  parameter int TC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  assign tc  = (cnt_q == W'(TC));
  assign cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (clr)         cnt_q <= '0;
    else if (ld)          cnt_q <= ld_val;
    else if (en && !tc)   cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/burst_initiator.sv
// Burst initiator: turns a length command into a do_req pulse train of L+1 cycles,
// counts returned strobes, and reports done/err/rx_cnt on the end-of-burst pulse or timeout.
module burst_initiator import burst_if_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF,
  parameter int TMO   = 16
) (
  input  logic                clk,
  input  logic                rst,
  burst_initiator_if.master   bus
);

  localparam int TMO_W = tmo_w(TMO);

  burst_state_e     state_q, state_d;
  logic             do_q, do_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sat_q, sat_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] rx_q, rx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tmo_clr, tmo_en, tmo_tc;
  logic [TMO_W-1:0] tmo_cnt;

  burst_tmo_cnt #(.W(TMO_W), .TC(TMO)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (tmo_en),
    .cnt    (tmo_cnt),
    .tc     (tmo_tc)
  );

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.do_req    = do_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rx_cnt    = rx_q;

  always_comb begin
    state_d = state_q;
    do_d    = do_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sat_d   = sat_q;
    rem_d   = rem_q;
    rx_d    = rx_q;
    len_d   = len_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;

    // A strobe beyond the counter's range is remembered so the burst always reports a mismatch
    if ((state_q == REQ || state_q == WAIT) && bus.s) begin
      if (rx_q == '1) sat_d = 1'b1;
      else            rx_d  = rx_q + LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.s || bus.g) err_d = 1'b1;
        if (bus.cmd_valid) begin
          len_d   = bus.cmd_len;
          rem_d   = bus.cmd_len;
          rx_d    = '0;
          sat_d   = 1'b0;
          do_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (rem_q == '0) begin
          do_d    = 1'b0;
          tmo_clr = 1'b1;
          state_d = WAIT;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      WAIT: begin
        tmo_en = 1'b1;
        if (bus.g || tmo_tc) begin
          done_d  = 1'b1;
          err_d   = !bus.g || sat_d || (rx_d != len_q);
          state_d = IDLE;
        end
      end
      default: begin
        do_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      do_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      rem_q   <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      do_q    <= do_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      rem_q   <= rem_d;
      rx_q    <= rx_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q <= len_d;
  end

endmodule

// File: tb/tb_burst_initiator.sv
// Directed and randomized bursts against a behavioural responder; expectations come from burst-level arithmetic.
module tb_burst_initiator;
  import burst_if_pkg::*;

  localparam int LW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_initiator_if #(.LEN_W(LW)) bus();

  burst_initiator #(.LEN_W(LW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Responder model: idle -> run on do; in run, do gives a strobe, its absence gives g.
  int   r_st;
  int   beat;
  logic s_r, g_r;
  logic inj_g = 1'b0;
  bit   drop_en = 1'b0;
  bit   no_g = 1'b0;
  int   drop_idx = 0;

  assign bus.s = s_r;
  assign bus.g = g_r | inj_g;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= 0; beat <= 0; s_r <= 1'b0; g_r <= 1'b0;
    end else begin
      s_r <= 1'b0;
      g_r <= 1'b0;
      case (r_st)
        0: if (bus.do_req) begin r_st <= 1; beat <= 0; end
        1: begin
          if (bus.do_req) begin
            s_r  <= !(drop_en && beat == drop_idx);
            beat <= beat + 1;
          end else begin
            g_r  <= !no_g;
            r_st <= 2;
          end
        end
        default: r_st <= 0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One burst of length L. preset: command already driven in the previous done cycle.
  // chain: present the next command (length nxt) during this burst's done cycle.
  task automatic run_burst(input string nm, input int L, input bit preset, input bit chain, input int nxt);
    int do_fall, done_cyc, exp_rx, exp_done;
    bit exp_err;
    logic e_at, rdy_at;
    logic [LW-1:0] r_at;
    do_fall = -1; done_cyc = -1; e_at = 1'bx; rdy_at = 1'bx; r_at = 'x;
    exp_rx   = (drop_en && L > 0) ? L - 1 : L;
    exp_err  = no_g || (exp_rx != L);
    exp_done = no_g ? L + TMO + 3 : L + 4;
    if (!preset) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LW'(L);
    end
    chk({nm, "_ready_at_cmd"}, bus.cmd_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= L + TMO + 12 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
      if (!bus.do_req && do_fall < 0) do_fall = k;
      if (bus.done) begin
        done_cyc = k; e_at = bus.err; r_at = bus.rx_cnt; rdy_at = bus.cmd_ready;
      end
    end
    chk({nm, "_do_fall_cycle"}, do_fall, L + 2);
    chk({nm, "_done_cycle"}, done_cyc, exp_done);
    chk({nm, "_err"}, e_at, exp_err);
    chk({nm, "_rx_cnt"}, r_at, exp_rx);
    chk({nm, "_ready_in_done"}, rdy_at, 1);
    if (chain) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LW'(nxt);
    end else begin
      @(negedge clk);
      chk({nm, "_done_width"}, {bus.done, bus.err}, 0);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_do", bus.do_req, 0);
    chk("rst_done_err", {bus.done, bus.err}, 0);
    chk("rst_rx_cnt", bus.rx_cnt, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    run_burst("l3", 3, 0, 0, 0);
    run_burst("l0", 0, 0, 0, 0);

    drop_en = 1'b1; drop_idx = 2;
    run_burst("drop5", 5, 0, 0, 0);
    drop_en = 1'b0;

    no_g = 1'b1;
    run_burst("no_g", 2, 0, 0, 0);
    no_g = 1'b0;

    run_burst("b2b_a", 2, 0, 1, 255);
    run_burst("b2b_b", 255, 1, 0, 0);

    for (int i = 0; i < 6; i++) begin
      int L;
      L = $urandom_range(0, 20);
      drop_en = (L > 0) && ($urandom_range(0, 1) == 1);
      drop_idx = (L > 0) ? $urandom_range(0, L - 1) : 0;
      run_burst($sformatf("rnd%0d", i), L, 0, 0, 0);
    end
    drop_en = 1'b0;

    // Reset in the middle of a long request
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(10);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_do_before_rst", bus.do_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_do", bus.do_req, 0);
    chk("mid_rst_done_err", {bus.done, bus.err}, 0);
    chk("mid_rst_rx_cnt", bus.rx_cnt, 0);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inj_g = 1'b1;
    @(negedge clk);
    inj_g = 1'b0;
    chk("stray_g_err", bus.err, 1);
    chk("stray_g_no_done", bus.done, 0);
    chk("stray_g_ready", bus.cmd_ready, 1);
    @(negedge clk);
    chk("stray_g_err_width", bus.err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
